// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 4-bit LCD controller.
//   state_t     : top-level sequencing states
//   tx_phase_t  : phases of one timed nibble write
//   init nibble values, configuration byte table, long-command opcodes
package lcd_pkg;

  typedef enum logic [3:0] {
    S_POWERON,
    S_INIT_NIB,
    S_INIT_WAIT,
    S_CFG,
    S_HI,
    S_GAP,
    S_LO,
    S_EXEC,
    S_IDLE
  } state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SETUP,
    TX_PULSE,
    TX_HOLD,
    TX_DONE
  } tx_phase_t;

  localparam logic [3:0] INIT_NIB_8BIT = 4'h3;
  localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Function set 4-bit/2-line, entry mode increment, display on, clear.
  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_byte = 8'h28;
      2'd1:    cfg_byte = 8'h06;
      2'd2:    cfg_byte = 8'h0C;
      default: cfg_byte = 8'h01;
    endcase
  endfunction

  // Clear and return-home need the long wait; home ignores bit 0 (0x02/0x03).
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    is_long_cmd = !rs && ((b == CMD_CLEAR) || (b[7:1] == CMD_HOME[7:1]));
  endfunction

  // A wait of 0 cycles behaves as a wait of 1.
  function automatic int unsigned at_least_one(input int unsigned n);
    at_least_one = (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// One timed 4-bit write to the LCD bus.
//   clk_i, rst_i : clock, synchronous active-high reset
//   start_i      : 1-cycle strobe, latches rs_i/data_i
//   en_o         : LCD E, high for PULSE cycles after SETUP cycles
//   rs_o, data_o : latched RS/nibble while a write is active, else 0
//   done_o       : 1-cycle strobe after the hold time
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP = 2,
  parameter int unsigned PULSE = 12,
  parameter int unsigned HOLD  = 1,
  parameter int          CNT_W = 20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [3:0] data_i,
  output logic       en_o,
  output logic       rs_o,
  output logic [3:0] data_o,
  output logic       done_o
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(at_least_one(SETUP) - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(at_least_one(PULSE) - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(at_least_one(HOLD) - 1);

  tx_phase_t        phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic [3:0]       data_q, data_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= TX_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q + 1'b1;
    rs_d    = rs_q;
    data_d  = data_q;
    done_o  = 1'b0;
    case (phase_q)
      TX_IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          phase_d = TX_SETUP;
          rs_d    = rs_i;
          data_d  = data_i;
        end
      end
      TX_SETUP: if (cnt_q == SETUP_LAST) begin phase_d = TX_PULSE; cnt_d = '0; end
      TX_PULSE: if (cnt_q == PULSE_LAST) begin phase_d = TX_HOLD;  cnt_d = '0; end
      TX_HOLD:  if (cnt_q == HOLD_LAST)  begin phase_d = TX_DONE;  cnt_d = '0; end
      TX_DONE: begin
        done_o  = 1'b1;
        phase_d = TX_IDLE;
        cnt_d   = '0;
      end
      default: phase_d = TX_IDLE;
    endcase
  end

  // RS/data are held through the DONE cycle so they stay put from start to done.
  assign en_o   = (phase_q == TX_PULSE);
  assign rs_o   = (phase_q != TX_IDLE) && rs_q;
  assign data_o = (phase_q != TX_IDLE) ? data_q : 4'h0;

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 4-bit LCD controller: power-on init, configuration, then byte
// writes over a valid/ready handshake with per-command execution delays.
//   Clock, Reset         : clock, synchronous active-high reset
//   iData, iRS, iValid   : byte request (iRS 0=command, 1=data)
//   oReady, oInitDone    : handshake ready, init finished
//   oBusy                : any activity other than idle
//   oLCD_*               : LCD pins (E, RS, RW=0, StrataFlash=1, DB7..DB4)
//
// state       | meaning
// S_POWERON   | wait POWERON_CYCLES after reset
// S_INIT_NIB  | send init nibble (3,3,3,2)
// S_INIT_WAIT | wait INIT_WAIT_CYCLES after an init nibble
// S_CFG       | load next configuration byte into the byte path
// S_HI        | send high nibble of the current byte
// S_GAP       | wait NIBBLE_GAP_CYCLES between nibbles
// S_LO        | send low nibble of the current byte
// S_EXEC      | wait EXEC_CYCLES, or CLEAR_CYCLES for clear/home
// S_IDLE      | ready for a byte once init is done
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned POWERON_CYCLES    = 750000,
  parameter int unsigned INIT_WAIT_CYCLES  = 205000,
  parameter int unsigned EXEC_CYCLES       = 2000,
  parameter int unsigned CLEAR_CYCLES      = 82000,
  parameter int unsigned NIBBLE_GAP_CYCLES = 50,
  parameter int unsigned EN_SETUP_CYCLES   = 2,
  parameter int unsigned EN_PULSE_CYCLES   = 12,
  parameter int unsigned EN_HOLD_CYCLES    = 1,
  parameter int          TIMER_W           = 20
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iValid,
  output logic       oReady,
  output logic       oInitDone,
  output logic       oBusy,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  localparam longint unsigned TIMER_SPAN = 64'd1 << TIMER_W;

  if (POWERON_CYCLES >= TIMER_SPAN || INIT_WAIT_CYCLES >= TIMER_SPAN ||
      EXEC_CYCLES >= TIMER_SPAN || CLEAR_CYCLES >= TIMER_SPAN ||
      NIBBLE_GAP_CYCLES >= TIMER_SPAN || EN_SETUP_CYCLES >= TIMER_SPAN ||
      EN_PULSE_CYCLES >= TIMER_SPAN || EN_HOLD_CYCLES >= TIMER_SPAN) begin : g_timer_too_narrow
    $error("TIMER_W too narrow for the largest cycle parameter");
  end

  localparam logic [TIMER_W-1:0] PWR_LAST   = TIMER_W'(at_least_one(POWERON_CYCLES) - 1);
  localparam logic [TIMER_W-1:0] INIT_LAST  = TIMER_W'(at_least_one(INIT_WAIT_CYCLES) - 1);
  localparam logic [TIMER_W-1:0] EXEC_LAST  = TIMER_W'(at_least_one(EXEC_CYCLES) - 1);
  localparam logic [TIMER_W-1:0] CLEAR_LAST = TIMER_W'(at_least_one(CLEAR_CYCLES) - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST   = TIMER_W'(at_least_one(NIBBLE_GAP_CYCLES) - 1);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         nib_idx_q, nib_idx_d;
  logic [1:0]         cfg_idx_q, cfg_idx_d;
  logic               cfg_mode_q, cfg_mode_d;
  logic [7:0]         byte_q, byte_d;
  logic               rs_q, rs_d;
  logic               init_done_q, init_done_d;

  logic       tx_start, tx_rs, tx_done;
  logic [3:0] tx_data;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= S_POWERON;
      timer_q     <= '0;
      nib_idx_q   <= '0;
      cfg_idx_q   <= '0;
      cfg_mode_q  <= 1'b0;
      byte_q      <= '0;
      rs_q        <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      nib_idx_q   <= nib_idx_d;
      cfg_idx_q   <= cfg_idx_d;
      cfg_mode_q  <= cfg_mode_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 1'b1;
    nib_idx_d   = nib_idx_q;
    cfg_idx_d   = cfg_idx_q;
    cfg_mode_d  = cfg_mode_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    init_done_d = init_done_q;
    tx_start    = 1'b0;
    tx_rs       = 1'b0;
    tx_data     = 4'h0;
    case (state_q)
      S_POWERON: if (timer_q == PWR_LAST) state_d = S_INIT_NIB;
      S_INIT_NIB: begin
        // The timer is 0 only on the entry cycle, giving a single start strobe.
        tx_start = (timer_q == '0);
        tx_data  = (nib_idx_q == 2'd3) ? INIT_NIB_4BIT : INIT_NIB_8BIT;
        if (tx_done) state_d = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (timer_q == INIT_LAST) begin
          if (nib_idx_q == 2'd3) begin
            nib_idx_d  = '0;
            cfg_idx_d  = '0;
            cfg_mode_d = 1'b1;
            state_d    = S_CFG;
          end else begin
            nib_idx_d = nib_idx_q + 1'b1;
            state_d   = S_INIT_NIB;
          end
        end
      end
      S_CFG: begin
        byte_d  = cfg_byte(cfg_idx_q);
        rs_d    = 1'b0;
        state_d = S_HI;
      end
      S_HI: begin
        tx_start = (timer_q == '0);
        tx_rs    = rs_q;
        tx_data  = byte_q[7:4];
        if (tx_done) state_d = S_GAP;
      end
      S_GAP: if (timer_q == GAP_LAST) state_d = S_LO;
      S_LO: begin
        tx_start = (timer_q == '0);
        tx_rs    = rs_q;
        tx_data  = byte_q[3:0];
        if (tx_done) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (timer_q == (is_long_cmd(rs_q, byte_q) ? CLEAR_LAST : EXEC_LAST)) begin
          if (!cfg_mode_q) begin
            state_d = S_IDLE;
          end else if (cfg_idx_q == 2'd3) begin
            cfg_mode_d  = 1'b0;
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            cfg_idx_d = cfg_idx_q + 1'b1;
            state_d   = S_CFG;
          end
        end
      end
      S_IDLE: begin
        timer_d = timer_q;
        if (iValid && init_done_q) begin
          byte_d  = iData;
          rs_d    = iRS;
          state_d = S_HI;
        end
      end
      default: state_d = S_POWERON;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  lcd_nibble_tx #(
    .SETUP(EN_SETUP_CYCLES),
    .PULSE(EN_PULSE_CYCLES),
    .HOLD (EN_HOLD_CYCLES),
    .CNT_W(TIMER_W)
  ) u_nibble_tx (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .start_i(tx_start),
    .rs_i   (tx_rs),
    .data_i (tx_data),
    .en_o   (oLCD_Enabled),
    .rs_o   (oLCD_RegisterSelect),
    .data_o (oLCD_Data),
    .done_o (tx_done)
  );

  assign oReady                  = (state_q == S_IDLE) && init_done_q;
  assign oInitDone               = init_done_q;
  assign oBusy                   = (state_q != S_IDLE);
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
module tb_lcd_hd44780_ctrl;

  localparam int POWERON = 20;
  localparam int INITW   = 8;
  localparam int EXEC    = 4;
  localparam int CLEAR   = 10;
  localparam int GAP     = 2;
  localparam int SETUP   = 2;
  localparam int PULSE   = 3;
  localparam int HOLD    = 1;
  localparam int BUDGET  = 2000;

  logic       Clock, Reset, iRS, iValid;
  logic [7:0] iData;
  logic       oReady, oInitDone, oBusy;
  logic       oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite, oLCD_StrataFlashControl;
  logic [3:0] oLCD_Data;

  lcd_hd44780_ctrl #(
    .POWERON_CYCLES(POWERON), .INIT_WAIT_CYCLES(INITW), .EXEC_CYCLES(EXEC),
    .CLEAR_CYCLES(CLEAR), .NIBBLE_GAP_CYCLES(GAP), .EN_SETUP_CYCLES(SETUP),
    .EN_PULSE_CYCLES(PULSE), .EN_HOLD_CYCLES(HOLD), .TIMER_W(16)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iData(iData), .iRS(iRS), .iValid(iValid),
    .oReady(oReady), .oInitDone(oInitDone), .oBusy(oBusy),
    .oLCD_Enabled(oLCD_Enabled), .oLCD_RegisterSelect(oLCD_RegisterSelect),
    .oLCD_ReadWrite(oLCD_ReadWrite), .oLCD_StrataFlashControl(oLCD_StrataFlashControl),
    .oLCD_Data(oLCD_Data)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accepts = 0;
  int initdone_cyc = -1;

  // observed E pulses
  int p_data[$];
  int p_rs[$];
  int p_rise[$];
  int p_fall[$];
  // reference model: expected nibble stream
  int e_data[$];
  int e_rs[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    Clock = 0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    forever begin
      @(posedge Clock);
      if (!Reset && iValid && oReady) accepts++;
      cyc++;
    end
  end

  // Bus monitor: pulse width, setup/hold stability, pulse log.
  initial begin
    logic       e_prev;
    int         hi_cnt, hold_left;
    logic [3:0] d_h1, d_h2, cur_d;
    logic       r_h1, r_h2, cur_r;
    e_prev = 0; hi_cnt = 0; hold_left = 0;
    d_h1 = 0; d_h2 = 0; r_h1 = 0; r_h2 = 0; cur_d = 0; cur_r = 0;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        e_prev = 0; hi_cnt = 0; hold_left = 0; initdone_cyc = -1;
      end else begin
        if (oInitDone && initdone_cyc < 0) initdone_cyc = cyc;
        if (oLCD_Enabled && !e_prev) begin
          chk("setup_data", {d_h2, d_h1}, {oLCD_Data, oLCD_Data});
          chk("setup_rs", {r_h2, r_h1}, {oLCD_RegisterSelect, oLCD_RegisterSelect});
          cur_d = oLCD_Data; cur_r = oLCD_RegisterSelect;
          p_data.push_back(int'(oLCD_Data));
          p_rs.push_back(int'(oLCD_RegisterSelect));
          p_rise.push_back(cyc);
          hi_cnt = 1;
        end else if (oLCD_Enabled) begin
          hi_cnt++;
          chk("pulse_stable", {oLCD_RegisterSelect, oLCD_Data}, {cur_r, cur_d});
        end
        if (!oLCD_Enabled && e_prev) begin
          chk("pulse_width", hi_cnt, PULSE);
          p_fall.push_back(cyc);
          hold_left = HOLD;
        end
        if (!oLCD_Enabled && hold_left > 0) begin
          chk("hold_stable", {oLCD_RegisterSelect, oLCD_Data}, {cur_r, cur_d});
          hold_left--;
        end
        e_prev = oLCD_Enabled;
      end
      d_h2 = d_h1; d_h1 = oLCD_Data;
      r_h2 = r_h1; r_h1 = oLCD_RegisterSelect;
    end
  end

  function automatic int wait_for(input int b, input int rs);
    return (rs == 0 && b >= 1 && b <= 3) ? CLEAR : EXEC;
  endfunction

  task automatic model_byte(input int b, input int rs);
    e_data.push_back(b >> 4);   e_rs.push_back(rs);
    e_data.push_back(b & 15);   e_rs.push_back(rs);
  endtask

  task automatic step();
    @(negedge Clock); #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!oReady && n < BUDGET) begin step(); n++; end
    chk({tag, "_timeout"}, oReady, 1);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_count"}, p_data.size(), e_data.size());
    for (int i = 0; i < e_data.size() && i < p_data.size(); i++) begin
      chk({tag, "_nibble"}, p_data[i], e_data[i]);
      chk({tag, "_rs"}, p_rs[i], e_rs[i]);
    end
  endtask

  task automatic reset_pulse(input int n);
    Reset = 1;
    repeat (n) begin @(posedge Clock); #1; end
    p_data.delete(); p_rs.delete(); p_rise.delete(); p_fall.delete();
    e_data.delete(); e_rs.delete();
  endtask

  // Sends one byte; returns accept->ready latency in cycles.
  task automatic send(input int b, input int rs, input bit hold_valid, output int lat);
    int acc_cyc, acc0, k;
    wait_ready("pre_send");
    acc0 = accepts;
    iData = 8'(b); iRS = rs[0]; iValid = 1;
    @(posedge Clock); #1;
    acc_cyc = cyc;
    chk("ready_drop", oReady, 0);
    if (!hold_valid) iValid = 0;
    model_byte(b, rs);
    step();
    wait_ready("byte_done");
    iValid = 0;
    lat = cyc - acc_cyc;
    chk("single_accept", accepts - acc0, 1);
    k = p_fall.size();
    cmp_stream("byte");
    if (k >= 2) begin
      chk("nibble_gap", (p_rise[k-1] - p_fall[k-2]) >= (GAP + SETUP), 1);
      chk("exec_wait", cyc - p_fall[k-1], wait_for(b, rs) + HOLD + 1);
    end
  endtask

  initial begin
    int rel, base, lat, b, rs;
    Reset = 1; iValid = 0; iData = 0; iRS = 0;
    @(posedge Clock); #1;
    chk("rst_e", oLCD_Enabled, 0);
    chk("rst_rs", oLCD_RegisterSelect, 0);
    chk("rst_data", oLCD_Data, 0);
    chk("rst_ready", oReady, 0);
    chk("rst_initdone", oInitDone, 0);
    chk("rst_busy", oBusy, 1);
    chk("rst_rw_sf", {oLCD_ReadWrite, oLCD_StrataFlashControl}, 2'b01);
    reset_pulse(2);

    // power-on init + configuration
    Reset = 0; rel = cyc;
    e_data = '{3, 3, 3, 2}; e_rs = '{0, 0, 0, 0};
    model_byte(8'h28, 0); model_byte(8'h06, 0); model_byte(8'h0C, 0); model_byte(8'h01, 0);
    wait_ready("init");
    cmp_stream("init");
    chk("init_done", oInitDone, 1);
    if (p_rise.size() >= 12) begin
      chk("poweron_wait", (p_rise[0] - rel) >= (POWERON + SETUP), 1);
      for (int i = 0; i < 3; i++)
        chk("init_wait", (p_rise[i+1] - p_fall[i]) >= (INITW + SETUP), 1);
      chk("initdone_delay", initdone_cyc - p_fall[11], CLEAR + HOLD + 1);
      chk("ready_with_done", cyc, initdone_cyc);
    end

    // data byte, measures the fixed accept->ready latency for a short wait
    send(8'h41, 1, 0, base);
    chk("lat_sane", base >= 2 * (SETUP + PULSE + HOLD + 1) + GAP + EXEC, 1);

    // clear with iValid held through busy
    send(8'h01, 0, 1, lat);
    chk("lat_clear", lat, base + CLEAR - EXEC);
    repeat (3) step();
    chk("no_second_xfer", {oReady, oBusy}, 2'b10);

    // random bytes
    for (int i = 0; i < 12; i++) begin
      b = $urandom_range(0, 255);
      rs = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) begin b = $urandom_range(1, 3); rs = 0; end
      send(b, rs, 0, lat);
      chk("lat_rand", lat, base + wait_for(b, rs) - EXEC);
    end

    // reset while E high mid-byte
    wait_ready("pre_abort");
    iData = 8'hA5; iRS = 1; iValid = 1;
    @(posedge Clock); #1;
    iValid = 0;
    begin
      int n = 0;
      while (!oLCD_Enabled && n < 100) begin step(); n++; end
    end
    chk("abort_e_seen", oLCD_Enabled, 1);
    Reset = 1;
    @(posedge Clock); #1;
    chk("abort_e", oLCD_Enabled, 0);
    chk("abort_data", oLCD_Data, 0);
    chk("abort_rs", oLCD_RegisterSelect, 0);
    chk("abort_flags", {oReady, oInitDone, oBusy}, 3'b001);
    reset_pulse(1);
    Reset = 0; rel = cyc;
    e_data = '{3, 3, 3, 2}; e_rs = '{0, 0, 0, 0};
    model_byte(8'h28, 0); model_byte(8'h06, 0); model_byte(8'h0C, 0); model_byte(8'h01, 0);
    wait_ready("reinit");
    cmp_stream("reinit");
    if (p_rise.size() > 0)
      chk("repoweron_wait", (p_rise[0] - rel) >= (POWERON + SETUP), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
- Parametrised successor to the fixed-sequence LCD init FSM for the 4-bit character LCD on the board.
- Runs the full HD44780 4-bit power-on init, then accepts command/data bytes over a valid/ready handshake.
- Splits each byte into two timed nibble writes and enforces the required execution delays.
- Sits between the application text/command logic and the LCD pins.

Parameters:
- POWERON_CYCLES, 750000, wait after reset before first init nibble (15 ms at 50 MHz)
- INIT_WAIT_CYCLES, 205000, wait after each power-on init nibble (4.1 ms)
- EXEC_CYCLES, 2000, wait after a normal byte (40 us)
- CLEAR_CYCLES, 82000, wait after clear (0x01) or home (0x02/0x03) with RS=0 (1.64 ms)
- NIBBLE_GAP_CYCLES, 50, gap between high and low nibble of one byte (1 us)
- EN_SETUP_CYCLES, 2, RS/data stable before enable rises
- EN_PULSE_CYCLES, 12, enable high time
- EN_HOLD_CYCLES, 1, data held after enable falls
- TIMER_W, 20, delay counter width; must hold the largest cycle parameter

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- iData  in  8  byte to write
- iRS  in  1  0=command, 1=data
- iValid  in  1  byte request
- oReady  out  1  ctrl can accept a byte this cycle
- oInitDone  out  1  power-on init and configuration finished
- oBusy  out  1  nibble write or wait in progress
- oLCD_Enabled  out  1  LCD E
- oLCD_RegisterSelect  out  1  LCD RS
- oLCD_ReadWrite  out  1  tied 0
- oLCD_StrataFlashControl  out  1  tied 1
- oLCD_Data  out  4  LCD DB7..DB4

Behaviour:
- One clock (Clock). Reset is synchronous and active-high.
- While Reset is high at a rising edge, the next cycle shows:
  - oLCD_Enabled=0, oLCD_RegisterSelect=0, oLCD_Data=0
  - oReady=0, oInitDone=0, oBusy=1
  - state=S_POWERON, timer=0
- Reset mid-transfer aborts immediately; no partial enable pulse survives.
- Nibble write (nibble_tx), started by a 1-cycle start strobe:
  - Drive RS/data, wait EN_SETUP_CYCLES.
  - Raise E for EN_PULSE_CYCLES.
  - Lower E, hold data EN_HOLD_CYCLES.
  - Pulse done for 1 cycle.
  - RS and data must not change from start through done.
- States:
  - S_POWERON: count POWERON_CYCLES -> S_INIT_NIB.
  - S_INIT_NIB: send the init nibbles 0x3, 0x3, 0x3, 0x2 (RS=0), each followed by S_INIT_WAIT of INIT_WAIT_CYCLES. A 2-bit index selects the nibble. After the 4th nibble -> S_CFG.
  - S_CFG: send config bytes 0x28, 0x06, 0x0C, 0x01 via the byte path with their wait rules. After the last byte: oInitDone=1 and stays 1 until Reset -> S_IDLE.
  - S_IDLE: oReady=1, oBusy=0. On iValid&&oReady, latch iData/iRS -> S_HI.
  - S_HI: send iData[7:4] -> S_GAP (NIBBLE_GAP_CYCLES) -> S_LO.
  - S_LO: send iData[3:0] -> S_EXEC.
  - S_EXEC: wait CLEAR_CYCLES if RS=0 and byte is 0x01, 0x02 or 0x03; otherwise EXEC_CYCLES -> S_IDLE.
- Handshake:
  - oReady is high only in S_IDLE with oInitDone=1.
  - iValid while not ready is ignored; no queuing. The byte is accepted on the cycle iValid&&oReady, and oReady drops the next cycle.
  - Back-to-back minimum: accept-to-accept = 2*(setup+pulse+hold+1) + gap + exec + small fixed overhead. This is implementation-defined but constant; the bench measures it once.
- Timer:
  - Loads 0 on every state entry and counts up.
  - A wait of N cycles completes when timer==N-1.
  - A parameter of 0 is treated as 1.
  - The timer never wraps inside a wait; elaboration asserts that every parameter < 2^TIMER_W.
- oLCD_Data=0 and oLCD_RegisterSelect=0 whenever no nibble write is active.
- oBusy = !(state==S_IDLE).

Decomposition:
- Package lcd_pkg: state enum, init nibble constants (0x3, 0x2), config byte list (0x28, 0x06, 0x0C, 0x01), long-command opcodes (0x01, 0x02).
- One sub-module, lcd_nibble_tx: owns the setup/pulse/hold counter, the E output and the done strobe.
- Top FSM owns the sequencing, waits and handshake.

Test Plan (sim params POWERON=20, INIT_WAIT=8, EXEC=4, CLEAR=10, GAP=2, SETUP=2, PULSE=3, HOLD=1):
- Reset release -> no E for 20 cycles; E pulses carry nibbles 3,3,3,2 with RS=0, each E high exactly 3 cycles and >=8 cycles between pulses.
- Config check -> nibble stream 2,8,0,6,0,C,0,1 with RS=0; oInitDone rises only after 10 cycles following the last nibble; oReady=1 next.
- Send iData=0x41, iRS=1 -> nibbles 4 then 1 with RS=1 throughout; 2-cycle gap between pulses; 4-cycle wait; oReady back.
- Send 0x01 with RS=0 -> post-byte wait is 10 cycles, not 4; iValid held during busy does not produce a second transfer until oReady.
- Reset asserted while E is high mid-byte -> E=0 and oLCD_Data=0 the next cycle; full power-on sequence restarts from 20-cycle wait.
- Property: RS/data stable for 2 cycles before every E rise and 1 cycle after every E fall, across all of the above.
